// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, widths, arbiter FSM states and helpers
// that classify op codes by latency and legality.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  typedef enum logic [OPW-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLT = 4'd5,
    DIV = 4'd6,
    MUL = 4'd7,
    SLL = 4'd8,
    SRL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  function automatic logic is_multi_cycle(input logic [OPW-1:0] op);
    return (op == DIV) || (op == MUL);
  endfunction

  function automatic logic is_supported(input logic [OPW-1:0] op);
    return op <= SRL;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted; a single requester is always granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    // NOTE: grant takes a default before the conditional override so no latch is inferred.
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// operands held from registers for the op latency, registered valid/ready result.
module alu_arbiter #(
  parameter int WIDTH     = alu_pkg::WIDTH,
  parameter int OPW       = alu_pkg::OPW,
  parameter int MULTI_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y
);

  import alu_pkg::*;

  localparam logic [3:0] MULTI_CNT = 4'(MULTI_LAT - 1);

  arb_state_e       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic             err_q;
  logic [3:0]       cnt;
  logic [1:0]       grant;
  logic             idle;
  logic             take;
  logic             sel;
  logic [OPW-1:0]   op_in;
  logic [WIDTH-1:0] y_cap;

  assign idle = (state == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   ({req1_valid, req0_valid}),
    .advance (idle),
    .grant   (grant)
  );

  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign take       = req0_ready || req1_ready;
  assign sel        = req1_ready;
  assign op_in      = sel ? req1_op : req0_op;

  // Unsupported ops report zero regardless of what the ALU produces for them.
  assign y_cap = err_q ? '0 : alu_y;

  // ALU inputs come straight from registers so they cannot glitch during EXEC.
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: operand registers are reset too because they drive the ALU ports directly.
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (take) begin
            a_q   <= sel ? req1_a : req0_a;
            b_q   <= sel ? req1_b : req0_b;
            op_q  <= op_in;
            id_q  <= sel;
            err_q <= !is_supported(op_in);
            cnt   <= is_multi_cycle(op_in) ? MULTI_CNT : 4'd0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_y     <= y_cap;
            rsp_zero  <= (y_cap == '0);
            rsp_err   <= err_q;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives alu_y, stimulus
// pushes expected responses on accept, a negedge monitor pops and compares.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int LAT_M = 3;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_y;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;

  alu_arbiter #(.WIDTH(32), .OPW(4), .MULTI_LAT(LAT_M)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unsigned ALU; undefined op codes return a junk pattern.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (a < b) ? 32'd1 : 32'd0;
      4'd6:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd7:    return a * b;
      4'd8:    return a << b[4:0];
      4'd9:    return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_y = alu_fn(alu_a, alu_b, alu_op);

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          busy    = 0;
  bit          in_exec = 0;
  bit          last    = 1;
  bit          prev_valid = 0;
  int          acc_cyc, cur_lat;
  logic [31:0] cur_a, cur_b;
  logic [3:0]  cur_op;
  bit          rnd_done;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: reference round-robin, latency, operand hold and scoreboard checks.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      busy       = 0;
      in_exec    = 0;
      last       = 1;
      prev_valid = 0;
    end else begin
      logic [1:0] exp_r;
      bit         id;
      exp_t       e;
      logic [31:0] a, b;
      logic [3:0]  op;

      if (busy) begin
        check("ready_while_busy", {req1_ready, req0_ready}, 2'b00);
      end else if (req0_valid || req1_valid) begin
        if (req0_valid && req1_valid) exp_r = last ? 2'b01 : 2'b10;
        else                          exp_r = {req1_valid, req0_valid};
        check("grant", {req1_ready & req1_valid, req0_ready & req0_valid}, exp_r);
      end

      if (in_exec && !rsp_valid) begin
        check("alu_hold", {alu_a, alu_b, alu_op}, {cur_a, cur_b, cur_op});
        if (cyc >= acc_cyc + cur_lat) begin
          check("rsp_valid_late", rsp_valid, 1'b1);
          in_exec = 0;
        end
      end
      if (rsp_valid && !prev_valid && in_exec) begin
        check("rsp_latency", cyc - acc_cyc, cur_lat);
        in_exec = 0;
      end

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_spurious", rsp_valid, 1'b0);
        end else begin
          check("rsp_id", rsp_id, sb[0].id);
          check("rsp_y", rsp_y, sb[0].y);
          check("rsp_zero", rsp_zero, sb[0].zero);
          check("rsp_err", rsp_err, sb[0].err);
          if (rsp_ready) begin
            void'(sb.pop_front());
            busy = 0;
          end
        end
      end
      prev_valid = rsp_valid;

      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        id     = !(req0_valid && req0_ready);
        a      = id ? req1_a : req0_a;
        b      = id ? req1_b : req0_b;
        op     = id ? req1_op : req0_op;
        e.id   = id;
        e.err  = (op > 4'd9);
        e.y    = e.err ? 32'd0 : alu_fn(a, b, op);
        e.zero = (e.y == 32'd0);
        sb.push_back(e);
        busy    = 1;
        in_exec = 1;
        acc_cyc = cyc + 1;
        cur_lat = (op == 4'd6 || op == 4'd7) ? LAT_M : 1;
        cur_a   = a;
        cur_b   = b;
        cur_op  = op;
        last    = id;
      end
    end
  end

  task automatic drive(input bit id, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Hold a request until ready, then release it after the accepting edge.
  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    bit done = 0;
    drive(id, 1'b1, a, b, op);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = id ? req1_ready : req0_ready;
    end
    check("send_accepted", done, 1'b1);
    @(posedge clk); #1;
    drive(id, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // One-cycle request that may be withdrawn before it is accepted.
  task automatic poke(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    drive(id, 1'b1, a, b, op);
    @(posedge clk); #1;
    drive(id, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (sb.size() != 0 || busy); i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input bit id);
    logic [31:0] a, b;
    logic [3:0]  op;
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    op = 4'($urandom_range(0, 15));
    if (op == 4'd6 && b == 32'd0) b = 32'd1;
    if ($urandom_range(0, 7) == 0) poke(id, a, b, op);
    else                           send(id, a, b, op);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, alu_a, alu_b, alu_op}, '0);
    reset = 1'b0;

    // Single ADD from requester 0.
    send(1'b0, 32'd5, 32'd7, ADD);
    drain();

    // Both requesters continuously valid: grants must alternate.
    fork
      begin send(1'b0, 32'd9, 32'd9, SUB); send(1'b0, 32'd10, 32'd3, AND); end
      begin send(1'b1, 32'd1, 32'd2, OR);  send(1'b1, 32'd12, 32'd10, XOR); end
    join
    drain();

    // Multi-cycle multiply from requester 1.
    send(1'b1, 32'd6, 32'd7, MUL);
    drain();

    // Response stall with requester 0 already waiting.
    rsp_ready = 1'b0;
    fork
      begin send(1'b0, 32'd20, 32'd22, ADD); send(1'b0, 32'd3, 32'd3, XOR); end
      begin
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        check("stall_rsp_seen", rsp_valid, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Unsupported op and shifts.
    send(1'b0, 32'd11, 32'd22, 4'hC);
    send(1'b0, 32'd1, 32'd4, SLL);
    send(1'b0, 32'h80, 32'd7, SRL);
    send(1'b1, 32'd2, 32'd9, SLT);
    drain();

    // Reset during a divide in EXEC: no response, outputs cleared at once.
    send(1'b0, 32'd100, 32'd7, DIV);
    reset = 1'b1;
    #1;
    check("reset_mid_exec", {rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, alu_a, alu_b, alu_op}, '0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("no_rsp_after_reset", rsp_valid, 1'b0);
    send(1'b0, 32'd3, 32'd4, ADD);
    drain();

    // Randomized traffic with random backpressure.
    rnd_done = 0;
    fork
      begin
        fork
          begin for (int k = 0; k < 40; k++) rand_req(1'b0); end
          begin for (int k = 0; k < 40; k++) rand_req(1'b1); end
        join
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
